pokey_poly_checker: RTL and testbench

POKEY_POLY_CHECKER -- requirements
Module: pokey_poly_checker

---
 rtl/pokey_poly_pkg.sv | 23 ++
 rtl/pokey_poly_predict.sv | 15 +
 rtl/pokey_poly_checker.sv | 146 ++++++++++++++
 tb/tb_pokey_poly_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pokey_poly_pkg.sv
// Shared types and constants for the POKEY polynomial stream checker.
package pokey_poly_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } chk_state_e;

    localparam int HIST_W  = 17;
    localparam int LEN17   = 17;
    localparam int LEN9    = 9;
    localparam int TAP17_A = 11;
    localparam int TAP17_B = 16;
    localparam int TAP9_A  = 3;
    localparam int TAP9_B  = 8;

    // Number of samples needed to refill the history for the given mode.
    function automatic logic [4:0] poly_len(input logic mode9);
        return mode9 ? 5'(LEN9) : 5'(LEN17);
    endfunction

endpackage

// File: rtl/pokey_poly_predict.sv
// Combinational next-bit predictor: XNOR of the two feedback taps of the active polynomial.
module pokey_poly_predict
    import pokey_poly_pkg::*;
(
    input  logic [HIST_W-1:0] hist_i,
    input  logic              mode9_i,
    output logic              pred_o
);

    always_comb begin
        if (mode9_i) pred_o = ~(hist_i[TAP9_A] ^ hist_i[TAP9_B]);
        else         pred_o = ~(hist_i[TAP17_A] ^ hist_i[TAP17_B]);
    end

endmodule

// File: rtl/pokey_poly_checker.sv
// Locks onto a received POKEY 9/17-bit poly stream and flags mispredicted bits.
// Define POKEY_POLY_CHK_COUNT_EN to build the saturating err_count counter.
module pokey_poly_checker
    import pokey_poly_pkg::*;
#(
    parameter int LOCK_MATCHES = 32,
    parameter int LOSS_MISSES  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bit_in,
    input  logic        select_9_17,
    input  logic        clear,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count,
    output logic [1:0]  state_out
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_MATCHES);
    localparam logic [3:0] LOSS_N = 4'(LOSS_MISSES);

    chk_state_e        state_q, state_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic              mode9_q, mode9_d;
    logic [4:0]        fill_q, fill_d;
    logic [7:0]        match_q, match_d;
    logic [3:0]        miss_q, miss_d;
    logic              locked_q, err_q, err_d;
    logic              pred;

    pokey_poly_predict u_predict (
        .hist_i  (hist_q),
        .mode9_i (mode9_q),
        .pred_o  (pred)
    );

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        mode9_d = mode9_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (enable) begin
            hist_d = {hist_q[HIST_W-2:0], bit_in};
            // A mode change restarts the fill, with this sample already counted.
            if (select_9_17 != mode9_q) begin
                mode9_d = select_9_17;
                state_d = SEED;
                fill_d  = 5'd1;
                match_d = '0;
                miss_d  = '0;
            end else begin
                unique case (state_q)
                    SEED: begin
                        fill_d = fill_q + 5'd1;
                        if (fill_d == poly_len(mode9_q)) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end
                    VERIFY: begin
                        if (bit_in == pred) begin
                            if (match_q + 8'd1 == LOCK_N) begin
                                state_d = LOCK;
                                match_d = '0;
                                miss_d  = '0;
                            end else begin
                                match_d = match_q + 8'd1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCK: begin
                        if (bit_in != pred) begin
                            err_d = 1'b1;
                            if (miss_q + 4'd1 == LOSS_N) begin
                                state_d = SEED;
                                fill_d  = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                    default: state_d = SEED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            hist_q   <= '0;
            mode9_q  <= 1'b0;
            fill_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            mode9_q  <= mode9_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= (state_d == LOCK);
            err_q    <= err_d;
        end
    end

`ifdef POKEY_POLY_CHK_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts on err_d so the count moves in the same cycle the err pulse appears.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)                          cnt_d = '0;
        else if (err_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign err_count = cnt_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign err_count    = '0;
`endif

    assign locked    = locked_q;
    assign err       = err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_pokey_poly_checker.sv
// Directed bench: a software poly stream drives one default checker and a
// fast-losing checker used for the counter saturation run.
module tb_pokey_poly_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, bin = 1'b0, sel = 1'b0, clr = 1'b0;
    logic        locked, err;
    logic [15:0] err_count;
    logic [1:0]  state_out;

    logic        s_rst = 1'b0, s_en = 1'b0, s_bin = 1'b0, s_clr = 1'b0;
    logic        s_locked, s_err;
    logic [15:0] s_cnt;
    logic [1:0]  s_state;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    logic [16:0] hist, shist;
    logic [16:0] seedv = 17'h1ACE5;

    always #5 clk = ~clk;

    pokey_poly_checker u_dut (
        .clk(clk), .reset(rst), .enable(en), .bit_in(bin), .select_9_17(sel),
        .clear(clr), .locked(locked), .err(err), .err_count(err_count),
        .state_out(state_out)
    );

    pokey_poly_checker #(.LOCK_MATCHES(1), .LOSS_MISSES(15)) u_sat (
        .clk(clk), .reset(s_rst), .enable(s_en), .bit_in(s_bin), .select_9_17(1'b0),
        .clear(s_clr), .locked(s_locked), .err(s_err), .err_count(s_cnt),
        .state_out(s_state)
    );

    function automatic int ecnt(input int v);
`ifdef POKEY_POLY_CHK_COUNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic logic nxt17(input logic [16:0] h);
        return ~(h[11] ^ h[16]);
    endfunction

    function automatic logic nxt9(input logic [16:0] h);
        return ~(h[3] ^ h[8]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic b);
        bin = b; en = 1'b1;
        @(posedge clk); #1;
        hist = {hist[15:0], b};
        if (err) pulses++;
    endtask

    task automatic idle();
        en = 1'b0; bin = ~bin;
        @(posedge clk); #1;
    endtask

    task automatic ssend(input logic b);
        s_bin = b; s_en = 1'b1;
        @(posedge clk); #1;
        shist = {shist[15:0], b};
    endtask

    initial begin
        fork
            begin : main_flow
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                chk("rst_state",  32'(state_out), 0);
                chk("rst_locked", 32'(locked), 0);
                chk("rst_err",    32'(err), 0);
                chk("rst_cnt",    32'(err_count), 0);
                rst = 1'b0; hist = '0;

                // 17-bit acquisition and long clean run
                for (int i = 0; i < 17; i++) send(seedv[i]);
                chk("seed_to_verify", 32'(state_out), 1);
                for (int i = 0; i < 31; i++) send(nxt17(hist));
                chk("lock_48", 32'(locked), 0);
                send(nxt17(hist));
                chk("lock_49", 32'(locked), 1);
                chk("lock_state", 32'(state_out), 2);
                pulses = 0;
                for (int n = 49; n < 10000; n++) send(nxt17(hist));
                chk("run_pulses", 32'(pulses), 0);
                chk("run_cnt",    32'(err_count), 0);
                chk("run_locked", 32'(locked), 1);

                // single flipped bit
                pulses = 0;
                send(~nxt17(hist));
                chk("flip_err", 32'(err), 1);
                idle();
                chk("idle_err",   32'(err), 0);
                chk("idle_state", 32'(state_out), 2);
                for (int i = 0; i < 40; i++) send(nxt17(hist));
                chk("flip_pulses", 32'(pulses), 1);
                chk("flip_locked", 32'(locked), 1);
                chk("flip_cnt",    32'(err_count), 32'(ecnt(1)));

                // clear, then stuck-at-0 input until lock is lost
                clr = 1'b1; idle(); clr = 1'b0;
                chk("clear_cnt", 32'(err_count), 0);
                begin
                    int k;
                    k = 0;
                    while (k < 2000 && !(hist[11] == hist[16] && hist[10] == hist[15] &&
                                         hist[9] == hist[14])) begin
                        send(nxt17(hist));
                        k++;
                    end
                    chk("zero_window_found", 32'(k < 2000), 1);
                end
                pulses = 0;
                send(1'b0);
                chk("stuck_err1", 32'(err), 1);
                chk("stuck_lock1", 32'(locked), 1);
                send(1'b0);
                chk("stuck_err2", 32'(err), 1);
                chk("stuck_lock2", 32'(locked), 1);
                send(1'b0);
                chk("stuck_err3",   32'(err), 1);
                chk("stuck_state",  32'(state_out), 0);
                chk("stuck_locked", 32'(locked), 0);
                chk("stuck_pulses", 32'(pulses), 3);
                chk("stuck_cnt",    32'(err_count), 32'(ecnt(3)));

                // reacquire in 17-bit mode
                for (int i = 0; i < 48; i++) send(nxt17(hist));
                chk("relock17_48", 32'(locked), 0);
                send(nxt17(hist));
                chk("relock17_49", 32'(locked), 1);

                // switch to 9-bit mode while locked
                sel = 1'b1;
                send(nxt9(hist));
                chk("mode_sw_state",  32'(state_out), 0);
                chk("mode_sw_locked", 32'(locked), 0);
                for (int i = 0; i < 39; i++) send(nxt9(hist));
                chk("relock9_40", 32'(locked), 0);
                chk("relock9_vfy", 32'(state_out), 1);
                send(nxt9(hist));
                chk("relock9_41", 32'(locked), 1);
                chk("relock9_state", 32'(state_out), 2);

                // back to 17-bit, reset while verifying
                sel = 1'b0;
                for (int i = 0; i < 20; i++) send(nxt17(hist));
                chk("pre_rst_state", 32'(state_out), 1);
                chk("pre_rst_cnt",   32'(err_count), 32'(ecnt(3)));
                rst = 1'b1; en = 1'b1; bin = nxt17(hist);
                @(posedge clk); #1;
                rst = 1'b0; en = 1'b0; hist = '0;
                chk("mid_rst_state",  32'(state_out), 0);
                chk("mid_rst_locked", 32'(locked), 0);
                chk("mid_rst_cnt",    32'(err_count), 0);
            end
            begin : sat_flow
                s_rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                s_rst = 1'b0; shist = '0;
                for (int i = 0; i < 17; i++) ssend(seedv[i]);
                ssend(nxt17(shist));
                chk("sat_locked", 32'(s_locked), 1);
                // 4681 x 14 = 65534 errors, never 15 in a row
                for (int g = 0; g < 4681; g++) begin
                    for (int i = 0; i < 14; i++) ssend(~nxt17(shist));
                    ssend(nxt17(shist));
                end
                chk("sat_preload", 32'(s_cnt), 32'(ecnt(16'hFFFE)));
                chk("sat_still_locked", 32'(s_locked), 1);
                ssend(~nxt17(shist));
                chk("sat_ffff", 32'(s_cnt), 32'(ecnt(16'hFFFF)));
                ssend(~nxt17(shist));
                chk("sat_hold1", 32'(s_cnt), 32'(ecnt(16'hFFFF)));
                ssend(~nxt17(shist));
                chk("sat_hold2", 32'(s_cnt), 32'(ecnt(16'hFFFF)));
                s_clr = 1'b1;
                ssend(~nxt17(shist));
                s_clr = 1'b0;
                chk("sat_clr_err", 32'(s_err), 1);
                chk("sat_clr_cnt", 32'(s_cnt), 0);
                s_en = 1'b0;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
